if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction fetch unit that owns the program counter and produces the instruction/PC+4 pair written into the IF/ID pipeline register. It runs one outstanding request at a time on a variable-latency instruction-memory handshake. It holds a fetched instruction until the hazard unit releases the stall, and it handles branch/jump redirects by discarding in-flight or held instructions. When no instruction is available it presents an all-zero bubble, matching the IF/ID flush encoding.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  downstream not accepting (IF/ID write_enable low)
- redirect  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  32  target PC; bits [1:0] ignored, forced to 2'b00
- imem_req  out  1  request valid
- imem_addr  out  32  request address (current PC)
- imem_gnt  in  1  memory accepted the request this cycle
- imem_rvalid  in  1  read data valid; never in the same cycle as the corresponding gnt
- imem_rdata  in  32  read data
- fetch_valid  out  1  fetch_instruction/fetch_pc_plus_4 hold a real instruction
- fetch_instruction  out  32  instruction to IF/ID; 32'd0 when fetch_valid=0
- fetch_pc_plus_4  out  32  PC of that instruction + 4; 32'd0 when fetch_valid=0

## Operation
- States:
  - IDLE: entered on reset only.
  - FETCH: imem_req=1, imem_addr=pc.
  - WAIT: request granted, awaiting rvalid.
  - HOLD: fetch_valid=1.
- Transitions:
  - IDLE -> FETCH unconditionally on the first edge after reset release.
  - FETCH -> WAIT on imem_gnt.
  - WAIT -> HOLD on imem_rvalid. Capture rdata and pc+4; fetch_valid<=1.
  - HOLD and !stall -> FETCH. Instruction consumed; pc<=pc+4; fetch_valid<=0.
  - HOLD and stall: remain in HOLD; outputs unchanged.
- Redirect has priority over stall and over every normal transition:
  - IDLE: pc<=redirect_pc; go to FETCH.
  - FETCH without gnt: pc<=redirect_pc; stay in FETCH. imem_addr shows the new PC next cycle; memory must not latch an address without gnt.
  - FETCH with gnt in the same cycle: the old-PC request is live. pc<=redirect_pc; go to WAIT with discard<=1.
  - WAIT: pc<=redirect_pc; discard<=1; stay in WAIT. If rvalid arrives in that same cycle, drop the data and go to FETCH with discard=0.
  - HOLD: drop the held instruction; fetch_valid<=0; pc<=redirect_pc; go to FETCH.
- Discard: in WAIT with discard=1, rvalid drops the data, clears discard, and goes to FETCH. Only one response is ever dropped.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Reset (async, immediate): pc=RESET_PC, state=IDLE, discard=0, imem_req=0, imem_addr=RESET_PC, fetch_valid=0, fetch_instruction=0, fetch_pc_plus_4=0.
- imem_req and imem_addr are decoded from registered state/pc only; no combinational path from any input.
- fetch_* outputs are registered.
- Zero-wait memory (gnt in the request cycle, rvalid the following cycle): 3 cycles per instruction steady-state. Sequence: FETCH, WAIT, HOLD.
- First request: the 2nd rising edge after rst falls ends the first FETCH cycle.
- Latency from gnt to fetch_valid=1: rvalid latency + 1 edge.
- Redirect to first request at the target: the next cycle, except when a discard is pending.
- Stall held for N cycles in HOLD: instruction and pc+4 are held stable for N cycles, with no memory traffic.
- rst asserted mid-transaction: all state clears. The memory must abandon the outstanding request; an rvalid arriving after reset while in IDLE/FETCH is ignored.

## Test plan
- Reset, RESET_PC=32'h0000_0100, zero-wait memory, stall=0 -> imem_addr sequence 0x100, 0x104, 0x108, one request every 3 cycles; fetch_pc_plus_4 = 0x104, 0x108, 0x10C with matching rdata.
- Stall high 4 cycles while in HOLD holding 0x8C080004 -> fetch_valid=1 and the instruction is stable for 4 cycles; imem_req=0; the next address is issued 1 cycle after stall falls.
- Redirect to 0x0000_2003 in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> data dropped (fetch_valid stays 0); the next request address is 0x0000_2000.
- Redirect in the same cycle as imem_gnt for 0x200 -> the response is discarded; the next request is the redirect target; no instruction from 0x200 appears.
- Redirect and stall together in HOLD -> the held instruction is dropped, fetch_valid=0 next cycle, and a request to the target is issued.
- pc=0xFFFF_FFFC consumed -> fetch_pc_plus_4=0x0000_0000; the next imem_addr is 0x0000_0000.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory request
// at a time, and presents an instruction / PC+4 pair (or an all-zero bubble)
// to the IF/ID pipeline register. Redirects discard in-flight or held work.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_instruction,
  output logic [31:0] fetch_pc_plus_4
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] fetch_instr_q, fetch_instr_d;
  logic [31:0] fetch_pc4_q, fetch_pc4_d;

  logic [31:0] redir_target;
  logic [31:0] pc_plus_4;

  assign redir_target = redirect_pc & ~32'h0000_0003;
  assign pc_plus_4    = pc_q + 32'd4;

  // Next-state, PC and output-register update; redirect outranks everything.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    fetch_valid_d = fetch_valid_q;
    fetch_instr_d = fetch_instr_q;
    fetch_pc4_d   = fetch_pc4_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (redirect) begin
          pc_d = redir_target;
        end else begin
          pc_d = pc_q;
        end
      end
      S_FETCH: begin
        if (redirect) begin
          pc_d = redir_target;
          if (imem_gnt) begin
            // Old-PC request was accepted: its response must be thrown away.
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = redir_target;
          if (imem_rvalid) begin
            state_d   = S_FETCH;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_FETCH;
          end else begin
            state_d       = S_HOLD;
            fetch_valid_d = 1'b1;
            fetch_instr_d = imem_rdata;
            fetch_pc4_d   = pc_plus_4;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d       = S_FETCH;
          pc_d          = redir_target;
          fetch_valid_d = 1'b0;
          fetch_instr_d = 32'd0;
          fetch_pc4_d   = 32'd0;
        end else if (!stall) begin
          state_d       = S_FETCH;
          pc_d          = pc_plus_4;
          fetch_valid_d = 1'b0;
          fetch_instr_d = 32'd0;
          fetch_pc4_d   = 32'd0;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d       = S_IDLE;
        discard_d     = 1'b0;
        fetch_valid_d = 1'b0;
        fetch_instr_d = 32'd0;
        fetch_pc4_d   = 32'd0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      discard_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= 32'd0;
      fetch_pc4_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      discard_q     <= discard_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_pc4_q   <= fetch_pc4_d;
    end
  end

  // Request signals decode registered state only.
  assign imem_req          = (state_q == S_FETCH);
  assign imem_addr         = pc_q;
  assign fetch_valid       = fetch_valid_q;
  assign fetch_instruction = fetch_instr_q;
  assign fetch_pc_plus_4   = fetch_pc4_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by a randomized run,
// with a memory responder and a transaction-level PC/instruction model.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_pc_plus_4;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .fetch_valid(fetch_valid), .fetch_instruction(fetch_instruction),
    .fetch_pc_plus_4(fetch_pc_plus_4)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int delivered = 0;
  int gnt_pct   = 100;
  int lat_fixed = 1;
  int stray_cnt = 0;

  // Memory model: one outstanding read, counted down to its rvalid cycle.
  bit          outst = 1'b0;
  int          wcnt  = 0;
  logic [31:0] oaddr = 32'd0;
  // Architectural PC the fetch unit should be working on.
  logic [31:0] pc_exp = RST_PC;

  logic [31:0] mem_over [logic [31:0]];
  logic [31:0] gnt_addr_q [$];
  int          gnt_cyc_q  [$];
  logic [31:0] dlv_pc4_q  [$];
  int          dlv_cyc_q  [$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    else return a ^ 32'hC3C3_5A5A;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Invariants that hold after every clock edge.
  task automatic check_cycle();
    chk32("addr_is_pc", imem_addr, pc_exp);
    if (fetch_valid) begin
      chk32("pc_plus_4", fetch_pc_plus_4, pc_exp + 32'd4);
      chk32("instr", fetch_instruction, memf(pc_exp));
    end else begin
      chk32("bubble_instr", fetch_instruction, 32'd0);
      chk32("bubble_pc4", fetch_pc_plus_4, 32'd0);
    end
    if (imem_req) begin
      chk1("req_while_outstanding", outst, 1'b0);
      chk1("req_while_valid", fetch_valid, 1'b0);
    end else begin
      chk1("idle_no_req", imem_req, 1'b0);
    end
  endtask

  // One clock: drive memory response, take the edge, advance models, check.
  task automatic tick();
    logic        fv_pre;
    logic [31:0] addr_pre;
    int          lat;
    fv_pre   = fetch_valid;
    addr_pre = imem_addr;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    if (stray_cnt > 0 && !outst) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
      stray_cnt--;
    end else if (outst && wcnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(oaddr);
    end
    if (imem_req && !outst && int'($urandom_range(99)) < gnt_pct) imem_gnt = 1'b1;
    @(posedge clk);
    cyc++;
    if (outst && imem_rvalid) outst = 1'b0;
    else if (outst) wcnt--;
    if (imem_gnt) begin
      lat   = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(4, 1));
      outst = 1'b1;
      oaddr = addr_pre;
      wcnt  = lat - 1;
      gnt_addr_q.push_back(addr_pre);
      gnt_cyc_q.push_back(cyc);
    end
    if (redirect) pc_exp = redirect_pc & ~32'h0000_0003;
    else if (fv_pre && !stall) pc_exp = pc_exp + 32'd4;
    #1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    check_cycle();
    if (fetch_valid && !fv_pre) begin
      delivered++;
      dlv_pc4_q.push_back(fetch_pc_plus_4);
      dlv_cyc_q.push_back(cyc);
    end
  endtask

  task automatic run_until_valid(input int max);
    int n;
    n = 0;
    while (!fetch_valid && n < max) begin
      tick();
      n++;
    end
    chk1("wait_valid_timeout", fetch_valid, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    #1;
    outst  = 1'b0;
    pc_exp = RST_PC;
    chk1("rst_req", imem_req, 1'b0);
    chk32("rst_addr", imem_addr, RST_PC);
    chk1("rst_valid", fetch_valid, 1'b0);
    chk32("rst_instr", fetch_instruction, 32'd0);
    chk32("rst_pc4", fetch_pc_plus_4, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    #12;
    do_reset();

    // Zero-wait memory: request every 3 cycles, first grant on 2nd edge.
    gnt_pct = 100; lat_fixed = 1;
    repeat (9) tick();
    chk32("t1_ngnt", 32'(gnt_addr_q.size()), 32'd3);
    chk32("t1_addr0", gnt_addr_q[0], 32'h0000_0100);
    chk32("t1_addr1", gnt_addr_q[1], 32'h0000_0104);
    chk32("t1_addr2", gnt_addr_q[2], 32'h0000_0108);
    chk32("t1_cyc0", 32'(gnt_cyc_q[0]), 32'd2);
    chk32("t1_cyc1", 32'(gnt_cyc_q[1]), 32'd5);
    chk32("t1_cyc2", 32'(gnt_cyc_q[2]), 32'd8);
    chk32("t1_pc4_0", dlv_pc4_q[0], 32'h0000_0104);
    chk32("t1_pc4_1", dlv_pc4_q[1], 32'h0000_0108);
    chk32("t1_pc4_2", dlv_pc4_q[2], 32'h0000_010C);
    chk32("t1_dlv_cyc0", 32'(dlv_cyc_q[0]), 32'd3);

    // Stall 4 cycles in HOLD with 0x8C080004.
    mem_over[32'h0000_010C] = 32'h8C08_0004;
    tick();
    run_until_valid(20);
    stall = 1'b1;
    repeat (4) begin
      tick();
      chk1("t2_valid", fetch_valid, 1'b1);
      chk32("t2_instr", fetch_instruction, 32'h8C08_0004);
      chk1("t2_no_req", imem_req, 1'b0);
    end
    stall = 1'b0;
    tick();
    chk1("t2_req_after", imem_req, 1'b1);
    chk32("t2_addr_after", imem_addr, 32'h0000_0110);

    // Redirect in WAIT; stale response 2 cycles later is dropped.
    lat_fixed = 3;
    mem_over[32'h0000_0110] = 32'hDEAD_BEEF;
    tick();
    chk1("t3_in_wait", outst, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h0000_2003;
    tick();
    redirect = 1'b0;
    tick();
    chk1("t3_valid_low", fetch_valid, 1'b0);
    tick();
    chk1("t3_valid_low2", fetch_valid, 1'b0);
    chk1("t3_req", imem_req, 1'b1);
    chk32("t3_addr", imem_addr, 32'h0000_2000);

    // Redirect in the same cycle as the grant for 0x200.
    gnt_pct = 0;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    chk32("t4_addr200", imem_addr, 32'h0000_0200);
    gnt_pct = 100; lat_fixed = 1;
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    chk1("t4_granted", outst, 1'b1);
    tick();
    chk1("t4_req", imem_req, 1'b1);
    chk32("t4_addr300", imem_addr, 32'h0000_0300);
    chk1("t4_no_valid", fetch_valid, 1'b0);
    run_until_valid(20);
    chk32("t4_pc4", fetch_pc_plus_4, 32'h0000_0304);

    // Redirect and stall together in HOLD.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0400;
    tick();
    stall = 1'b0; redirect = 1'b0;
    chk1("t5_valid", fetch_valid, 1'b0);
    chk1("t5_req", imem_req, 1'b1);
    chk32("t5_addr", imem_addr, 32'h0000_0400);

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    run_until_valid(20);
    chk32("t6_pc4_wrap", fetch_pc_plus_4, 32'h0000_0000);
    tick();
    chk1("t6_req", imem_req, 1'b1);
    chk32("t6_addr_wrap", imem_addr, 32'h0000_0000);

    // Randomized traffic with a mid-run reset and stray rvalids afterwards.
    lat_fixed = 0;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        stray_cnt = 2;
      end
      if (i % 100 == 0) gnt_pct = int'($urandom_range(100, 20));
      stall       = (int'($urandom_range(99)) < 30);
      redirect    = (int'($urandom_range(99)) < 5);
      redirect_pc = $urandom;
      tick();
    end
    stall = 1'b0; redirect = 1'b0;
    chk1("random_deliveries", delivered > 50, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
